// File: rtl/memory_pkg.sv
// memory_pkg: shared types and parameter helpers for latency_memory.
//   mem_state_t  access FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   mem_op_t     operation latched at accept
//   is_pow2 / cnt_width / params_ok  elaboration-time parameter helpers
package memory_pkg;

    typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} mem_state_t;
    typedef enum logic {MEM_OP_READ, MEM_OP_WRITE} mem_op_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Width of the latency down-counter; it only ever holds LATENCY-1.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

    function automatic bit params_ok(input int depth, input int addr_w, input int latency);
        return is_pow2(depth) && (depth >= 2) && (addr_w >= $clog2(depth)) && (latency >= 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W storage, synchronous write, registered read.
//   clk    clock
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index, sampled every rising edge
//   rdata  registered read data (old contents on a same-address write)
// Contents are intentionally not reset.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/latency_memory.sv
// latency_memory: single-port data memory with configurable width, depth
// and access latency, using a level request / one-cycle ready handshake.
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   read/write   level requests, held until ready (read wins if both)
//   address      word address, sampled at accept
//   write_value  write data, sampled at accept
//   read_value   read data, valid with ready, held until next read completes
//   ready        one-cycle completion pulse, LATENCY cycles after accept
//   busy         high from accept until the cycle after ready
//   error        out-of-range flag, qualified by ready
// Optional feature macro: MEMORY_BOUNDS_CHECK_EN
//   defined   - nonzero upper address bits flag an error, suppress the
//               write and return 0 on a read
//   undefined - upper address bits ignored (wrap modulo DEPTH), error = 0
module latency_memory
    import memory_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_value,
    output logic [DATA_W-1:0] read_value,
    output logic              ready,
    output logic              busy,
    output logic              error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(LATENCY);

    generate
        if (!params_ok(DEPTH, ADDR_W, LATENCY)) begin : g_param_err
            $error("latency_memory: DEPTH must be a power of two >= 2, ADDR_W >= log2(DEPTH), LATENCY >= 1");
        end
    endgenerate

    mem_state_t        state;
    mem_op_t           op_q;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oob_q;
    logic [CW-1:0]     counter;
    logic [DATA_W-1:0] held_value;
    logic              rd_sel;
    logic [DATA_W-1:0] rdata;

    logic              req;
    mem_op_t           op_in;
    logic              oob_in;
    logic              enter_done;
    mem_op_t           c_op;
    logic [AW-1:0]     c_addr;
    logic [DATA_W-1:0] c_data;
    logic              c_oob;
    logic              we;

    assign req   = read | write;
    assign op_in = read ? MEM_OP_READ : MEM_OP_WRITE;

`ifdef MEMORY_BOUNDS_CHECK_EN
    // Shift rather than slice so ADDR_W == AW needs no special case.
    assign oob_in = (address >> AW) != '0;
`else
    logic unused_upper_addr;
    assign unused_upper_addr = ^address;
    assign oob_in            = 1'b0;
`endif

    // The edge that enters DONE is the commit edge. With LATENCY=1 that is
    // the accept edge itself, so the commit operands come straight from the
    // ports; otherwise they come from the values latched at accept.
    assign enter_done = ((state == MEM_IDLE) && req && (LATENCY == 1)) ||
                        ((state == MEM_BUSY) && (counter == CW'(1)));

    always_comb begin
        c_op   = op_q;
        c_addr = addr_q;
        c_data = wdata_q;
        c_oob  = oob_q;
        if (state == MEM_IDLE) begin
            c_op   = op_in;
            c_addr = address[AW-1:0];
            c_data = write_value;
            c_oob  = oob_in;
        end
    end

    assign we = enter_done && (c_op == MEM_OP_WRITE) && !c_oob;

    // The array's read register captures c_addr on the commit edge, so
    // during DONE rdata is exactly the value this read loaded.
    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (c_addr),
        .wdata (c_data),
        .raddr (c_addr),
        .rdata (rdata)
    );

    // rdata keeps changing after DONE, so its value is copied into
    // held_value on the way out of DONE and presented from there.
    assign read_value = rd_sel ? rdata : held_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MEM_IDLE;
            op_q       <= MEM_OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            oob_q      <= 1'b0;
            counter    <= '0;
            held_value <= '0;
            rd_sel     <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            ready  <= 1'b0;
            error  <= 1'b0;
            rd_sel <= 1'b0;

            case (state)
                MEM_IDLE: begin
                    if (req) begin
                        op_q    <= op_in;
                        addr_q  <= address[AW-1:0];
                        wdata_q <= write_value;
                        oob_q   <= oob_in;
                        counter <= CW'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= (LATENCY == 1) ? MEM_DONE : MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        state <= MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    // Requests are not sampled here; a held request is
                    // picked up in the following IDLE cycle.
                    state <= MEM_IDLE;
                    busy  <= 1'b0;
                    if (rd_sel) begin
                        held_value <= rdata;
                    end
                end
                default: begin
                    state <= MEM_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (enter_done) begin
                ready  <= 1'b1;
                error  <= c_oob;
                rd_sel <= (c_op == MEM_OP_READ) && !c_oob;
                if ((c_op == MEM_OP_READ) && c_oob) begin
                    held_value <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_latency_memory.sv
// Scoreboard bench for latency_memory: one instance with LATENCY=1 and one
// with LATENCY=4. The driver pushes the expected response when it issues a
// request; a negedge monitor pops and compares whenever ready is high.
module tb_latency_memory;

    logic        clk;
    logic        rst   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [15:0] addr  [2];
    logic [7:0]  wval  [2];
    logic [7:0]  rv    [2];
    logic        ready [2];
    logic        busy  [2];
    logic        err   [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] rv;
        logic       err;
        bit         chk_rv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    latency_memory #(.DATA_W(8), .DEPTH(128), .ADDR_W(16), .LATENCY(1)) u_mem1 (
        .clk(clk), .rst(rst[0]), .read(rd[0]), .write(wr[0]), .address(addr[0]),
        .write_value(wval[0]), .read_value(rv[0]), .ready(ready[0]), .busy(busy[0]),
        .error(err[0])
    );

    latency_memory #(.DATA_W(8), .DEPTH(128), .ADDR_W(16), .LATENCY(4)) u_mem4 (
        .clk(clk), .rst(rst[1]), .read(rd[1]), .write(wr[1]), .address(addr[1]),
        .write_value(wval[1]), .read_value(rv[1]), .ready(ready[1]), .busy(busy[1]),
        .error(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] erv, input logic eerr, input bit chk);
        exp_t e;
        e.rv = erv; e.err = eerr; e.chk_rv = chk;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ready[d] === 1'b1) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    check($sformatf("ready_without_request_d%0d", d), ready[d], 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    if (e.chk_rv) check($sformatf("read_value_d%0d", d), rv[d], e.rv);
                    check($sformatf("error_d%0d", d), err[d], e.err);
                end
            end
        end
    end

    // Count rising edges until ready is seen (bounded), tracking busy.
    task automatic wait_ready(input int d, output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (busy[d] !== 1'b1) busy_ok = 1'b0;
        end while (ready[d] !== 1'b1 && n < 50);
    endtask

    task automatic access(input int d, input bit r, input bit w, input logic [15:0] a,
                          input logic [7:0] wv, input logic [7:0] erv, input logic eerr,
                          input string tag);
        int n;
        bit bok;
        @(negedge clk);
        rd[d] = r; wr[d] = w; addr[d] = a; wval[d] = wv;
        push(d, erv, eerr, r);
        wait_ready(d, n, bok);
        rd[d] = 1'b0; wr[d] = 1'b0;
        check({tag, "_latency"}, n, (d == 0) ? 1 : 4);
        check({tag, "_busy_held"}, bok, 1);
        @(posedge clk);
        #1;
        check({tag, "_busy_drop"}, busy[d], 0);
        check({tag, "_ready_pulse"}, ready[d], 0);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_ready"}, ready[d], 0);
        check({tag, "_busy"}, busy[d], 0);
        check({tag, "_error"}, err[d], 0);
        check({tag, "_read_value"}, rv[d], 0);
    endtask

`ifdef MEMORY_BOUNDS_CHECK_EN
    localparam logic       OOB_ERR = 1'b1;
    localparam logic [7:0] EXP_M5  = 8'd11;
    localparam logic [7:0] EXP_OOB = 8'd0;
`else
    localparam logic       OOB_ERR = 1'b0;
    localparam logic [7:0] EXP_M5  = 8'd200;
    localparam logic [7:0] EXP_OOB = 8'd200;
`endif

    initial begin
        int n;
        bit bok;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wval[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "reset_d0");
        check_idle(1, "reset_d1");
        rst[0] = 1'b0; rst[1] = 1'b0;

        // LATENCY=1: basic write/read, read-wins, bounds / wrap
        access(0, 0, 1, 16'd102, 8'd123, 8'd0,   1'b0, "wr102");
        access(0, 1, 0, 16'd102, 8'd0,   8'd123, 1'b0, "rd102");
        access(0, 0, 1, 16'd7,   8'd9,   8'd0,   1'b0, "wr7");
        access(0, 1, 1, 16'd7,   8'd55,  8'd9,   1'b0, "rw7");
        access(0, 1, 0, 16'd7,   8'd0,   8'd9,   1'b0, "rd7_after_rw");
        access(0, 0, 1, 16'd5,   8'd11,  8'd0,   1'b0, "wr5");
        access(0, 0, 1, 16'h0085, 8'd200, 8'd0,  OOB_ERR, "wr_0085");
        access(0, 1, 0, 16'd5,   8'd0,   EXP_M5, 1'b0, "rd5");
        access(0, 1, 0, 16'h0085, 8'd0,  EXP_OOB, OOB_ERR, "rd_0085");

        // LATENCY=4: latency, abort by reset, back-to-back
        access(1, 0, 1, 16'd5, 8'd50, 8'd0,  1'b0, "l4_wr5");
        access(1, 1, 0, 16'd5, 8'd0,  8'd50, 1'b0, "l4_rd5");
        access(1, 0, 1, 16'd3, 8'd33, 8'd0,  1'b0, "l4_wr3");

        // write 77 @3, reset two edges after accept: no ready, no commit
        @(negedge clk);
        wr[1] = 1'b1; addr[1] = 16'd3; wval[1] = 8'd77;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_no_early_ready", ready[1], 0);
        rst[1] = 1'b1;
        wr[1]  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle(1, "abort_reset");
        rst[1] = 1'b0;
        bok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready[1] !== 1'b0 || busy[1] !== 1'b0) bok = 1'b0;
        end
        check("abort_stays_idle", bok, 1);
        access(1, 1, 0, 16'd3, 8'd0, 8'd33, 1'b0, "l4_rd3_after_abort");

        // held read: re-accepted in the IDLE cycle after DONE
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 16'd5;
        push(1, 8'd50, 1'b0, 1'b1);
        push(1, 8'd50, 1'b0, 1'b1);
        wait_ready(1, n, bok);
        check("b2b_first_latency", n, 4);
        check("b2b_first_busy", bok, 1);
        wait_ready(1, n, bok);
        rd[1] = 1'b0;
        check("b2b_second_gap", n, 5);
        @(posedge clk);
        #1;
        check("b2b_busy_drop", busy[1], 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("outstanding_d0", q0.size(), 0);
        check("outstanding_d1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
